q6: RTL and testbench
=====================

Q6 -- requirements
Module: q6

Interface
REQ-001 Parameter: ACTIVE_LOW, default 1, segment polarity. 1 means a lit segment is driven 0 (DE-series boards); 0 means a lit segment is driven 1.
REQ-002 Parameter: SYNC_STAGES, default 2, number of synchronizer flops on SW; legal range 1..4.
REQ-003 Port: CLOCK_50, input, 1 bit, sole clock; all state updates on its rising edge.
REQ-004 Port: RESET_N, input, 1 bit, reset; one clock; reset is asynchronous and active-low.
REQ-005 Port: SW, input, 4 bits, hex digit to display (0x0..0xF), may be asynchronous to CLOCK_50.
REQ-006 Port: HEX0, output, 7 bits, segment drive; bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g; registered output.

Function
REQ-007 SW SHALL pass through a SYNC_STAGES-deep flop chain; the last stage feeds the decoder.
REQ-008 The decoder SHALL be combinational from the last sync stage into a 7-bit output register driving HEX0; no combinational path from SW to HEX0.
REQ-009 Latency SHALL be SYNC_STAGES+1 rising edges from a stable SW change to the HEX0 update (3 edges at default).
REQ-010 For ACTIVE_LOW=1, HEX0 (bits g..a, hex) SHALL be: 0->40, 1->79, 2->24, 3->30, 4->19, 5->12, 6->02, 7->78, 8->00, 9->10, A->08, b->03, C->46, d->21, E->06, F->0E.
REQ-011 For ACTIVE_LOW=0, HEX0 SHALL be the bitwise inverse of the REQ-010 pattern for the same digit.
REQ-012 All 16 input codes SHALL be decoded; no don't-care or default blank for any 4-bit value.
REQ-013 Digits A..F SHALL use the glyphs A, b, C, d, E, F, so b and d are distinguishable from 8 and 0.
REQ-014 A held SW value SHALL hold HEX0 constant with no glitches on any cycle.
REQ-015 Back-to-back SW changes on consecutive cycles SHALL each appear on HEX0, in order, SYNC_STAGES+1 cycles later.

Reset
REQ-016 While RESET_N=0, all sync flops SHALL be 4'h0 and HEX0 SHALL show all segments dark: 7F for ACTIVE_LOW=1, 00 for ACTIVE_LOW=0. Reset takes effect immediately, with no clock edge needed.
REQ-017 After RESET_N deasserts, decoding SHALL resume on the next rising edge. HEX0 SHALL show the current SW digit after SYNC_STAGES+1 edges.
REQ-018 Reset asserted mid-operation SHALL discard any in-flight digit; that digit SHALL NOT appear on HEX0 after release.

Verification
REQ-019 Reset: RESET_N=0 with SW=5 -> HEX0=7F asynchronously; release, then 3 edges later -> HEX0=12.
REQ-020 Exhaustive sweep: SW=0..F, each held 4 cycles -> HEX0 matches every REQ-010 entry in sequence.
REQ-021 Latency: SW changes 8->1 just after an edge -> HEX0 stays 00 for 2 edges and becomes 79 on the 3rd edge.
REQ-022 Polarity: ACTIVE_LOW=0 with SW=0 -> HEX0=3F; with SW=8 -> HEX0=7F.
REQ-023 Stream: SW=A,b,C,d on consecutive cycles -> HEX0=08,03,46,21 on consecutive cycles starting at latency 3.
REQ-024 Mid-stream reset: SW=7, pulse RESET_N low for 1 cycle before the output updates -> HEX0=7F, then 78 exactly 3 edges after release.

Source files
------------

// File: rtl/q6.sv
// Seven-segment hex digit display: synchronizes SW into the CLOCK_50 domain,
// decodes the digit and drives a registered HEX0 with selectable polarity.
module q6 #(
    parameter int ACTIVE_LOW  = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic [3:0] SW,
    output logic [6:0] HEX0
);

    localparam logic [6:0] DARK = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

    logic [3:0] sync_q [SYNC_STAGES];
    logic [6:0] seg_low;
    logic [6:0] seg_drive;

    // SW is asynchronous to CLOCK_50; only the last stage is trusted.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 4'h0;
            end
        end else begin
            sync_q[0] <= SW;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Active-low glyphs (g..a); b and d use lowercase shapes to differ from 8 and 0.
    always_comb begin
        seg_low = 7'h7F;
        case (sync_q[SYNC_STAGES-1])
            4'h0: seg_low = 7'h40;
            4'h1: seg_low = 7'h79;
            4'h2: seg_low = 7'h24;
            4'h3: seg_low = 7'h30;
            4'h4: seg_low = 7'h19;
            4'h5: seg_low = 7'h12;
            4'h6: seg_low = 7'h02;
            4'h7: seg_low = 7'h78;
            4'h8: seg_low = 7'h00;
            4'h9: seg_low = 7'h10;
            4'hA: seg_low = 7'h08;
            4'hB: seg_low = 7'h03;
            4'hC: seg_low = 7'h46;
            4'hD: seg_low = 7'h21;
            4'hE: seg_low = 7'h06;
            4'hF: seg_low = 7'h0E;
            default: seg_low = 7'h7F;
        endcase
        seg_drive = (ACTIVE_LOW != 0) ? seg_low : ~seg_low;
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            HEX0 <= DARK;
        end else begin
            HEX0 <= seg_drive;
        end
    end

endmodule

// File: tb/tb_q6.sv
// Directed bench for q6: drives both polarity variants side by side from one
// SW/reset stimulus and checks hand-computed segment patterns.
module tb_q6;

    logic       CLOCK_50;
    logic       RESET_N;
    logic [3:0] SW;
    logic [6:0] hex0_lo;
    logic [6:0] hex0_hi;

    int checks = 0;
    int errors = 0;

    q6 #(.ACTIVE_LOW(1), .SYNC_STAGES(2)) dut_lo (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .SW       (SW),
        .HEX0     (hex0_lo)
    );

    q6 #(.ACTIVE_LOW(0), .SYNC_STAGES(2)) dut_hi (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .SW       (SW),
        .HEX0     (hex0_hi)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // Hand-written glyph table for the active-low board.
    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'h0: return 7'h40;  4'h1: return 7'h79;
            4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;
            4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;
            4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;
            4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic test_reset();
        SW = 4'h3;
        repeat (5) tick();
        checks++;
        if (hex0_lo !== 7'h30) begin
            errors++;
            $display("[TB] FAIL pre_reset: got %h expected 30", hex0_lo);
        end
        // Assert reset mid-cycle so no clock edge is involved.
        @(negedge CLOCK_50);
        #1;
        SW = 4'h5;
        RESET_N = 1'b0;
        #1;
        checks++;
        if (hex0_lo !== 7'h7F) begin
            errors++;
            $display("[TB] FAIL async_reset_lo: got %h expected 7f", hex0_lo);
        end
        checks++;
        if (hex0_hi !== 7'h00) begin
            errors++;
            $display("[TB] FAIL async_reset_hi: got %h expected 00", hex0_hi);
        end
        repeat (3) tick();
        checks++;
        if (hex0_lo !== 7'h7F) begin
            errors++;
            $display("[TB] FAIL reset_held: got %h expected 7f", hex0_lo);
        end
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        repeat (3) tick();
        checks++;
        if (hex0_lo !== 7'h12) begin
            errors++;
            $display("[TB] FAIL reset_release: got %h expected 12", hex0_lo);
        end
    endtask

    task automatic test_sweep();
        for (int d = 0; d < 16; d++) begin
            SW = d[3:0];
            repeat (3) tick();
            checks++;
            if (hex0_lo !== glyph(d[3:0])) begin
                errors++;
                $display("[TB] FAIL sweep_lo[%0h]: got %h expected %h", d, hex0_lo, glyph(d[3:0]));
            end
            checks++;
            if (hex0_hi !== ~glyph(d[3:0])) begin
                errors++;
                $display("[TB] FAIL sweep_hi[%0h]: got %h expected %h", d, hex0_hi, ~glyph(d[3:0]));
            end
            tick();
            checks++;
            if (hex0_lo !== glyph(d[3:0])) begin
                errors++;
                $display("[TB] FAIL hold[%0h]: got %h expected %h", d, hex0_lo, glyph(d[3:0]));
            end
        end
    endtask

    task automatic test_latency();
        logic [6:0] expect_seq [3];
        expect_seq[0] = 7'h00;
        expect_seq[1] = 7'h00;
        expect_seq[2] = 7'h79;
        SW = 4'h8;
        repeat (4) tick();
        checks++;
        if (hex0_lo !== 7'h00) begin
            errors++;
            $display("[TB] FAIL latency_setup: got %h expected 00", hex0_lo);
        end
        SW = 4'h1;
        for (int e = 0; e < 3; e++) begin
            tick();
            checks++;
            if (hex0_lo !== expect_seq[e]) begin
                errors++;
                $display("[TB] FAIL latency_edge%0d: got %h expected %h", e + 1, hex0_lo, expect_seq[e]);
            end
        end
    endtask

    task automatic test_polarity();
        SW = 4'h0;
        repeat (4) tick();
        checks++;
        if (hex0_hi !== 7'h3F) begin
            errors++;
            $display("[TB] FAIL polarity_0: got %h expected 3f", hex0_hi);
        end
        SW = 4'h8;
        repeat (4) tick();
        checks++;
        if (hex0_hi !== 7'h7F) begin
            errors++;
            $display("[TB] FAIL polarity_8: got %h expected 7f", hex0_hi);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] vals [4];
        logic [6:0] exp_seg [4];
        vals[0] = 4'hA; vals[1] = 4'hB; vals[2] = 4'hC; vals[3] = 4'hD;
        exp_seg[0] = 7'h08; exp_seg[1] = 7'h03; exp_seg[2] = 7'h46; exp_seg[3] = 7'h21;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (cyc < 4) SW = vals[cyc];
            tick();
            if (cyc >= 2) begin
                checks++;
                if (hex0_lo !== exp_seg[cyc-2]) begin
                    errors++;
                    $display("[TB] FAIL stream[%0d]: got %h expected %h", cyc - 2, hex0_lo, exp_seg[cyc-2]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        SW = 4'h2;
        repeat (4) tick();
        SW = 4'h7;
        tick();
        RESET_N = 1'b0;
        #1;
        checks++;
        if (hex0_lo !== 7'h7F) begin
            errors++;
            $display("[TB] FAIL mid_reset_dark: got %h expected 7f", hex0_lo);
        end
        tick();
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            checks++;
            if (hex0_lo !== ((e == 3) ? 7'h78 : 7'h40)) begin
                errors++;
                $display("[TB] FAIL mid_reset_edge%0d: got %h expected %h", e, hex0_lo,
                         (e == 3) ? 7'h78 : 7'h40);
            end
        end
    endtask

    initial begin
        RESET_N = 1'b1;
        SW = 4'h0;
        test_reset();
        test_sweep();
        test_latency();
        test_polarity();
        test_back_to_back();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
